// File: rtl/fp_mul_normalize.sv
// Post-multiply normalize / round-to-nearest-even / pack stage of the single-precision multiplier.
// Four-state sequencer: one operation accepted every four cycles, result held until the next one.
module fp_mul_normalize (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [47:0] prod,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic        nan_in,
    output logic [31:0] result,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StPack} state_t;

    state_t             state_q, state_d;
    logic [47:0]        prod_q;
    logic [7:0]         exp_a_q, exp_b_q;
    logic               sign_q, nan_q;
    logic signed [9:0]  exp_q;
    logic [22:0]        mant_q;
    logic               guard_q, sticky_q;
    logic [31:0]        result_q;
    logic               out_valid_q, overrun_q;

    logic [9:0]         exp_sum;
    logic               round_up;
    logic [23:0]        mant_rnd;
    logic               a_inf, b_inf, a_zero, b_zero;
    logic [31:0]        pack_result;

    // Biased sum minus bias; two's-complement wrap makes negative results come out right.
    assign exp_sum  = {2'b00, exp_a} + {2'b00, exp_b} - 10'd127;
    assign round_up = guard_q & (sticky_q | mant_q[0]);
    assign mant_rnd = {1'b0, mant_q} + {23'h0, round_up};

    assign a_inf  = (exp_a_q == 8'hFF);
    assign b_inf  = (exp_b_q == 8'hFF);
    assign a_zero = (exp_a_q == 8'h00);
    assign b_zero = (exp_b_q == 8'h00);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StNorm;
            StNorm:  state_d = StRound;
            StRound: state_d = StPack;
            StPack:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Special operands are judged on the captured exponents, never on the computed one.
    always_comb begin
        pack_result = {sign_q, exp_q[7:0], mant_q};
        if (nan_q || (a_inf && b_zero) || (b_inf && a_zero)) begin
            pack_result = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            pack_result = {sign_q, 8'hFF, 23'h0};
        end else if (a_zero || b_zero) begin
            pack_result = {sign_q, 31'h0};
        end else if (exp_q >= 10'sd255) begin
            pack_result = {sign_q, 8'hFF, 23'h0};
        end else if (exp_q <= 10'sd0) begin
            pack_result = {sign_q, 31'h0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q      <= 48'h0;
            exp_a_q     <= 8'h0;
            exp_b_q     <= 8'h0;
            sign_q      <= 1'b0;
            nan_q       <= 1'b0;
            exp_q       <= 10'sd0;
            mant_q      <= 23'h0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            result_q    <= 32'h0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            overrun_q   <= in_valid && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        prod_q  <= prod;
                        exp_a_q <= exp_a;
                        exp_b_q <= exp_b;
                        sign_q  <= sign_a ^ sign_b;
                        nan_q   <= nan_in;
                        exp_q   <= exp_sum;
                    end
                end
                StNorm: begin
                    if (prod_q[47]) begin
                        mant_q   <= prod_q[46:24];
                        guard_q  <= prod_q[23];
                        sticky_q <= |prod_q[22:0];
                        exp_q    <= exp_q + 10'sd1;
                    end else begin
                        mant_q   <= prod_q[45:23];
                        guard_q  <= prod_q[22];
                        sticky_q <= |prod_q[21:0];
                    end
                end
                StRound: begin
                    // Carry out of the rounded mantissa means it rolled over to the next binade.
                    if (mant_rnd[23]) begin
                        mant_q <= 23'h0;
                        exp_q  <= exp_q + 10'sd1;
                    end else begin
                        mant_q <= mant_rnd[22:0];
                    end
                end
                StPack: begin
                    result_q    <= pack_result;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != StIdle);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fp_mul_normalize.sv
// Self-checking bench for fp_mul_normalize: vector table through a result scoreboard,
// plus back-to-back, overrun and mid-operation reset sequences.
module tb_fp_mul_normalize;

    typedef struct {
        logic [47:0] prod;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic        sa;
        logic        sb;
        logic        nan;
        logic [31:0] expect_res;
    } vec_t;

    localparam int NumVecs = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [47:0] prod;
    logic [7:0]  exp_a, exp_b;
    logic        sign_a, sign_b, nan_in;
    logic [31:0] result;
    logic        out_valid, busy, overrun;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] sb_q[$];
    vec_t        vecs[NumVecs];

    always #5 clk = ~clk;

    fp_mul_normalize dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .prod      (prod),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .nan_in    (nan_in),
        .result    (result),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        prod   = v.prod;
        exp_a  = v.ea;
        exp_b  = v.eb;
        sign_a = v.sa;
        sign_b = v.sb;
        nan_in = v.nan;
    endtask

    task automatic pop_compare(input string name);
        logic [31:0] req;
        if (sb_q.size() == 0) begin
            check({name, "_unexpected_out_valid"}, 32'd1, 32'd0);
        end else begin
            req = sb_q.pop_front();
            check(name, result, req);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bit seen;
        drive(v);
        in_valid = 1'b1;
        sb_q.push_back(v.expect_res);
        tick();
        in_valid = 1'b0;
        check($sformatf("v%0d_busy_after_accept", idx), {31'h0, busy}, 32'd1);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 8) begin
            tick();
            lat++;
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            check($sformatf("v%0d_timeout", idx), 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end else begin
            check($sformatf("v%0d_latency", idx), lat, 32'd3);
            pop_compare($sformatf("v%0d_result", idx));
        end
        tick();
        check($sformatf("v%0d_pulse_end", idx), {31'h0, out_valid}, 32'd0);
        check($sformatf("v%0d_idle", idx), {31'h0, busy}, 32'd0);
    endtask

    initial begin
        int ov_cnt;
        int ovl_cnt;
        vecs[0]  = '{48'h6000_0000_0000, 8'd127, 8'd128, 1'b0, 1'b0, 1'b0, 32'h4040_0000};
        vecs[1]  = '{48'h8000_0180_0000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 32'h4000_0002};
        vecs[2]  = '{48'h8000_0080_0000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 32'h4000_0000};
        vecs[3]  = '{48'hFFFF_FF80_0000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 32'h4080_0000};
        vecs[4]  = '{48'h4000_0000_0000, 8'd254, 8'd254, 1'b0, 1'b0, 1'b0, 32'h7F80_0000};
        vecs[5]  = '{48'h4000_0000_0000, 8'd1,   8'd1,   1'b0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[6]  = '{48'h4000_0000_0000, 8'd0,   8'd130, 1'b1, 1'b0, 1'b0, 32'h8000_0000};
        vecs[7]  = '{48'h4000_0000_0000, 8'd255, 8'd0,   1'b0, 1'b0, 1'b0, 32'h7FC0_0000};
        vecs[8]  = '{48'h4000_0000_0000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b1, 32'h7FC0_0000};
        vecs[9]  = '{48'h4000_0000_0000, 8'd127, 8'd127, 1'b1, 1'b0, 1'b0, 32'hBF80_0000};
        vecs[10] = '{48'h4000_0000_0000, 8'd255, 8'd127, 1'b0, 1'b1, 1'b0, 32'hFF80_0000};
        vecs[11] = '{48'h4000_0060_0000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 32'h3F80_0001};
        vecs[12] = '{48'h4000_0000_0000, 8'd191, 8'd191, 1'b0, 1'b0, 1'b0, 32'h7F80_0000};
        vecs[13] = '{48'h4000_0000_0000, 8'd191, 8'd190, 1'b0, 1'b0, 1'b0, 32'h7F00_0000};
        vecs[14] = '{48'h4000_0000_0000, 8'd64,  8'd63,  1'b0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[15] = '{48'h4000_0000_0000, 8'd64,  8'd64,  1'b0, 1'b0, 1'b0, 32'h0080_0000};
        vecs[16] = '{48'h4000_0020_0000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 32'h3F80_0000};
        vecs[17] = '{48'h6000_0000_0000, 8'd127, 8'd128, 1'b1, 1'b1, 1'b0, 32'h4040_0000};
        vecs[18] = '{48'h8000_0000_0000, 8'd191, 8'd190, 1'b0, 1'b0, 1'b0, 32'h7F80_0000};
        vecs[19] = '{48'h8000_0000_0000, 8'd64,  8'd63,  1'b0, 1'b0, 1'b0, 32'h0080_0000};

        reset    = 1'b1;
        in_valid = 1'b0;
        drive(vecs[0]);
        tick();
        tick();
        check("reset_result", result, 32'h0);
        check("reset_out_valid", {31'h0, out_valid}, 32'd0);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_overrun", {31'h0, overrun}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NumVecs; i++) begin
            run_vec(vecs[i], i);
        end

        // in_valid held for 8 cycles: accepts at cycles 0 and 4, the other six overrun.
        drive(vecs[0]);
        in_valid = 1'b1;
        ov_cnt   = 0;
        ovl_cnt  = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) in_valid = 1'b0;
            if (i == 0 || i == 4) sb_q.push_back(vecs[0].expect_res);
            tick();
            if (overrun) ov_cnt++;
            if (out_valid) begin
                ovl_cnt++;
                pop_compare("b2b_result");
            end
        end
        check("b2b_out_valid_count", ovl_cnt, 32'd2);
        check("b2b_overrun_count", ov_cnt, 32'd6);

        // Reset while in NORM aborts the operation and clears the held result.
        drive(vecs[3]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("abort_busy_norm", {31'h0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_result", result, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'd0);
        ovl_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) ovl_cnt++;
        end
        check("abort_no_out_valid", ovl_cnt, 32'd0);

        // Reset wins over a simultaneous in_valid.
        in_valid = 1'b1;
        reset    = 1'b1;
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        check("reset_prio_busy", {31'h0, busy}, 32'd0);

        run_vec(vecs[1], 100);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
